// File: rtl/alu_result_checker.sv
// Self-checking consumer for the ALU output: recomputes the expected result, aligns it
// to the ALU latency, compares it and keeps pass/fail statistics plus the first mismatch.
module alu_result_checker #(
   parameter int data_width   = 32,
   parameter int LATENCY      = 1,
   parameter int CNT_WIDTH    = 16,
   parameter int NUM_CHECKS   = 0,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [data_width-1:0] A,
   input  logic [data_width-1:0] B,
   input  logic [3:0]            op,
   input  logic [data_width-1:0] R,
   input  logic                  flag,
   output logic [CNT_WIDTH-1:0]  pass_cnt,
   output logic [CNT_WIDTH-1:0]  fail_cnt,
   output logic                  error,
   output logic                  done,
   output logic [3:0]            first_fail_op,
   output logic [data_width-1:0] first_fail_exp,
   output logic [data_width-1:0] first_fail_R
);

   localparam int TOT_W = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
   localparam int MSB   = data_width - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4, OP_NOT = 4'd5,
      OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_SLT = 4'd9, OP_MUL = 4'd10
   } op_e;

   typedef enum logic [1:0] {WARMUP, CHECK, DONE, HALT} state_e;

   typedef struct packed {
      logic [3:0]            op;
      logic [data_width-1:0] r;
      logic                  flag;
   } res_t;

   res_t       golden;
   logic [4:0] shamt;

   assign shamt = B[4:0];

   always_comb begin
      // NOTE: default every field first so no opcode path can infer a latch.
      golden    = '0;
      golden.op = op;
      case (op)
         OP_ADD: begin
            golden.r    = A + B;
            golden.flag = (A[MSB] == B[MSB]) && (golden.r[MSB] != A[MSB]);
         end
         OP_SUB: begin
            golden.r    = A - B;
            golden.flag = (A[MSB] != B[MSB]) && (golden.r[MSB] != A[MSB]);
         end
         OP_AND:  golden.r = A & B;
         OP_OR:   golden.r = A | B;
         OP_XOR:  golden.r = A ^ B;
         OP_NOT:  golden.r = ~A;
         OP_SLL:  golden.r = A << shamt;
         OP_SRL:  golden.r = A >> shamt;
         OP_SRA:  golden.r = $signed(A) >>> shamt;
         OP_SLT:  golden.r = ($signed(A) < $signed(B)) ? data_width'(1) : '0;
         OP_MUL:  golden.r = A * B;
         default: golden.r = '0;
      endcase
      if (op inside {[OP_AND:OP_MUL]}) golden.flag = (golden.r == '0);
   end

   // Expected result and its valid bit travel together so the compare sees inputs from t-LATENCY.
   res_t               exp_pipe [LATENCY];
   logic [LATENCY-1:0] vld_pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         // NOTE: the delay line is cleared on reset so in-flight results can never leak into a compare.
         for (int i = 0; i < LATENCY; i++) exp_pipe[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage read the previous cycle's neighbour.
         vld_pipe    <= (vld_pipe << 1) | LATENCY'(1);
         exp_pipe[0] <= golden;
         for (int i = 1; i < LATENCY; i++) exp_pipe[i] <= exp_pipe[i-1];
      end
   end

   state_e           state;
   logic [TOT_W-1:0] tot;
   logic [TOT_W-1:0] tot_next;
   res_t             exp_q;
   logic             compare_en;
   logic             mismatch;
   logic             hit_limit;

   assign exp_q      = exp_pipe[LATENCY-1];
   assign compare_en = vld_pipe[LATENCY-1] && ((state == WARMUP) || (state == CHECK));
   assign mismatch   = (R != exp_q.r) || (flag != exp_q.flag);
   assign tot_next   = tot + 1'b1;
   assign hit_limit  = (NUM_CHECKS != 0) && (tot_next == TOT_W'(NUM_CHECKS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= WARMUP;
         tot            <= '0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         error          <= 1'b0;
         done           <= 1'b0;
         first_fail_op  <= '0;
         first_fail_exp <= '0;
         first_fail_R   <= '0;
      end else if (compare_en) begin
         tot <= tot_next;
         if (mismatch) begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
            if (!error) begin
               error          <= 1'b1;
               first_fail_op  <= exp_q.op;
               first_fail_exp <= exp_q.r;
               first_fail_R   <= R;
            end
         end else if (pass_cnt != CNT_MAX) begin
            pass_cnt <= pass_cnt + 1'b1;
         end
         // Reaching the check limit wins over halting on the same mismatch.
         if (hit_limit) begin
            state <= DONE;
            done  <= 1'b1;
         end else if (mismatch && (STOP_ON_FAIL != 0)) begin
            state <= HALT;
         end else begin
            state <= CHECK;
         end
      end
   end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Self-checking consumer sitting on the ALU output side of the ps02 test top.
- Taps the generator's A/B/op and the ALU's R/flag, and recomputes the expected result with a golden model.
- Aligns the golden result to the ALU latency, then compares and keeps pass/fail statistics.
- Latches the first mismatch so a bench or debug probe can read it.

Parameters:
- data_width, 32: width of A, B, R.
- LATENCY, 1: ALU cycles from A/B/op to R/flag; legal range 1..8.
- CNT_WIDTH, 16: width of the pass/fail counters.
- NUM_CHECKS, 0: number of compared results before done; 0 = run forever.
- STOP_ON_FAIL, 0: 1 = freeze all statistics after the first mismatch.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  data_width  signed operand A from the generator.
- B  in  data_width  signed operand B from the generator.
- op  in  4  opcode from the generator.
- R  in  data_width  signed ALU result.
- flag  in  1  ALU flag.
- pass_cnt  out  CNT_WIDTH  matching results.
- fail_cnt  out  CNT_WIDTH  mismatching results.
- error  out  1  sticky; set on the first mismatch.
- done  out  1  NUM_CHECKS comparisons completed.
- first_fail_op  out  4  op of the first mismatch.
- first_fail_exp  out  data_width  expected R of the first mismatch.
- first_fail_R  out  data_width  observed R of the first mismatch.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0; delay line cleared; valid pipe cleared; state WARMUP.
- Golden model is combinational on the current A, B, op. Results per opcode:
  - 0 ADD: R = A+B; flag = signed overflow.
  - 1 SUB: R = A-B; flag = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: R = ~A.
  - 6 SLL, 7 SRL, 8 SRA: shift A by B[4:0].
  - 9 SLT: R = 1 if A<B signed, else 0.
  - 10 MUL: R = low data_width bits of A*B.
  - For ops 2..10: flag = (R==0).
  - Ops 11..15: R = 0, flag = 0.
  - All arithmetic wraps modulo 2^data_width.
- Alignment: expected {R, flag} and a valid bit pass through a LATENCY-deep shift register. The comparison at cycle t uses the inputs from cycle t-LATENCY.
- Valid pipe: shifts in 1 every cycle after reset. A comparison occurs only when the pipe's output is 1, so the first LATENCY cycles after reset release are never compared.
- State machine:
  - WARMUP -> CHECK when the valid pipe output first goes to 1.
  - CHECK: each cycle, compare {R, flag} with the delayed expected value.
    - Match: pass_cnt++.
    - Mismatch: fail_cnt++.
  - CHECK -> DONE when pass_cnt+fail_cnt reaches NUM_CHECKS (NUM_CHECKS != 0). The comparison that reaches NUM_CHECKS is counted, and done rises in the same cycle as that count update.
  - CHECK -> HALT on the first mismatch when STOP_ON_FAIL=1. That mismatch is counted.
  - DONE and HALT hold until rst. Counters and first_fail_* are frozen; done stays 1 in DONE.
- First mismatch: error goes to 1 together with the fail_cnt increment. first_fail_op/exp/R are captured in the same cycle, and later mismatches never overwrite them.
- Simultaneous events: a mismatch on the NUM_CHECKS-th comparison sets error, increments fail_cnt and asserts done in the same cycle. DONE has priority over HALT.
- Saturation: counters saturate at 2^CNT_WIDTH-1. Saturation does not stop the NUM_CHECKS tally, which uses a separate internal counter of width max(CNT_WIDTH, 32).
- Reset mid-operation: rst in any state clears everything on the next edge and restarts WARMUP. Results still in flight in the ALU are discarded because the valid pipe was cleared.

Test Plan:
- Warm-up (LATENCY=1): ideal ALU model, release rst at cycle 0 -> no count change at cycle 1; pass_cnt=1 at cycle 2.
- ADD: A=5, B=7, op=0 with R=12, flag=0 -> pass_cnt+1, error=0.
- Overflow mismatch: A=0x7FFFFFFF, B=1, op=0; drive R=0x80000000, flag=0 (expected flag=1).
  - Response: fail_cnt=1, error=1, first_fail_op=0, first_fail_exp=0x80000000, first_fail_R=0x80000000.
- Done (NUM_CHECKS=4, correct ALU): run 10 cycles -> done=1 exactly when pass_cnt=4; pass_cnt stays 4 afterwards.
- Halt (STOP_ON_FAIL=1): corrupt R on check 3 of 6 -> pass_cnt=2, fail_cnt=1, error=1; no further change.
- Saturation and reset (CNT_WIDTH=4): run 20 good checks -> pass_cnt=15. Assert rst for 1 cycle -> all outputs 0 and warm-up repeats.
